// File: rtl/rib_ex_bridge_pkg.sv
// Shared definitions for the core data-port bridge: state encoding and default watchdog limit.
package rib_ex_bridge_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

    typedef enum logic [1:0] {
        IDLE = S_IDLE,
        REQ  = S_REQ,
        WAIT = S_WAIT,
        DONE = S_DONE
    } state_e;

endpackage

// File: rtl/rib_timeout_cnt.sv
// Saturating watchdog counter; expired_o flags the enabled cycle in which the count reaches TIMEOUT.
module rib_timeout_cnt
    import rib_ex_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/rib_ex_bridge.sv
// Turns the core's single-cycle data access into a registered req/gnt/rvalid transaction,
// stalling the core until the slave responds or the watchdog aborts the access.
module rib_ex_bridge
    import rib_ex_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT,
    parameter int unsigned CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] core_addr_i,
    input  logic [DATA_W-1:0] core_wdata_i,
    input  logic              core_req_i,
    input  logic              core_we_i,
    output logic [DATA_W-1:0] core_rdata_o,
    output logic              core_hold_o,
    output logic              core_err_o,
    output logic              m_req_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic              m_we_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic              m_gnt_i,
    input  logic              m_rvalid_i,
    input  logic [DATA_W-1:0] m_rdata_i
);

    state_e            state_q, state_d;
    logic              stale_q, stale_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              cnt_clr, cnt_en, cnt_expired;

    rib_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) u_timeout_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .expired_o (cnt_expired)
    );

    always_comb begin
        state_d     = state_q;
        stale_d     = stale_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        core_hold_o = 1'b0;
        m_req_o     = 1'b0;

        // The late response of an abandoned transaction is swallowed wherever it lands.
        if (stale_q && m_rvalid_i) begin
            stale_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                core_hold_o = core_req_i;
                if (core_req_i && !stale_q) begin
                    addr_d  = core_addr_i;
                    we_d    = core_we_i;
                    wdata_d = core_wdata_i;
                    cnt_clr = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                m_req_o     = 1'b1;
                core_hold_o = 1'b1;
                cnt_en      = 1'b1;
                if (m_gnt_i) begin
                    if (m_rvalid_i) begin
                        if (!we_q) begin
                            rdata_d = m_rdata_i;
                        end
                        state_d = DONE;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            WAIT: begin
                core_hold_o = 1'b1;
                cnt_en      = 1'b1;
                if (m_rvalid_i) begin
                    if (!we_q) begin
                        rdata_d = m_rdata_i;
                    end
                    state_d = DONE;
                end else if (cnt_expired) begin
                    // Slave still owes a response; remember to drop it when it finally shows up.
                    rdata_d = '0;
                    err_d   = 1'b1;
                    stale_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            stale_q <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stale_q <= stale_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign m_addr_o     = addr_q;
    assign m_we_o       = we_q;
    assign m_wdata_o    = wdata_q;
    assign core_rdata_o = rdata_q;
    assign core_err_o   = err_q;

endmodule
